// File: rtl/sram_pkg.sv
// sram_pkg: shared SRAM bus defaults, strobe polarities and responder state encoding
package sram_pkg;
   localparam int DEF_ADDR_W = 8;
   localparam int DEF_DATA_W = 8;
   localparam logic CE_ACTIVE = 1'b1;
   localparam logic OE_ACTIVE = 1'b1;
   localparam logic WE_ACTIVE = 1'b1;
   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RD_WAIT  = 2'd1,
      RD_DRIVE = 2'd2,
      WR_HOLD  = 2'd3
   } state_t;
endpackage

// File: rtl/sram_array.sv
// sram_array: DEPTH x DATA_W storage, synchronous write, asynchronous read, never reset
module sram_array #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8,
   parameter int DEPTH  = 2**ADDR_W
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);
   logic [DATA_W-1:0] mem [DEPTH];
   always_ff @(posedge clk)
      if (we) mem[waddr] <= wdata;
   assign rdata = mem[raddr];
endmodule

// File: rtl/sram_responder.sv
// sram_responder: memory-side SRAM device with read wait states, write protect, error flags and counters
module sram_responder
   import sram_pkg::*;
#(
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int DATA_W   = DEF_DATA_W,
   parameter int DEPTH    = 2**ADDR_W,
   parameter int READ_LAT = 0,
   parameter int CNT_W    = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] sram_addr,
   inout  wire  [DATA_W-1:0] sram_data,
   input  logic              sram_ce,
   input  logic              sram_oe,
   input  logic              sram_we,
   input  logic              wp_en,
   output logic              rdy,
   output logic              err_conflict,
   output logic              err_wp,
   output logic [CNT_W-1:0]  rd_count,
   output logic [CNT_W-1:0]  wr_count
);
   state_t state, state_n;
   logic ce_a, oe_a, we_a, rd_req, wr_req, conflict, bus_en;
   logic wr_en, rd_inc, load_wait, rd_done, abort, set_conf, set_wp;
   logic [2:0] wait_cnt;
   logic [ADDR_W-1:0] lat_addr;
   logic [DATA_W-1:0] dout, rd_data;
   assign ce_a     = sram_ce == CE_ACTIVE;
   assign oe_a     = sram_oe == OE_ACTIVE;
   assign we_a     = sram_we == WE_ACTIVE;
   assign rd_req   = ce_a & oe_a & ~we_a;
   assign wr_req   = ce_a & we_a & ~oe_a;
   assign conflict = ce_a & oe_a & we_a;
   // rd_req already excludes we and ce=0, so the bus is released combinationally in both cases
   assign bus_en    = ~rst & rd_req & (state == RD_DRIVE | (READ_LAT == 0 & state == IDLE));
   assign sram_data = bus_en ? (READ_LAT == 0 ? rd_data : dout) : 'z;
   sram_array #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) u_array (
      .clk   (clk),
      .we    (wr_en),
      .waddr (sram_addr),
      .wdata (sram_data),
      .raddr (sram_addr),
      .rdata (rd_data)
   );
   always_comb begin
      state_n   = state;
      wr_en     = 1'b0;
      rd_inc    = 1'b0;
      load_wait = 1'b0;
      rd_done   = 1'b0;
      abort     = 1'b0;
      set_conf  = 1'b0;
      set_wp    = 1'b0;
      case (state)
         IDLE:
            if (conflict) set_conf = 1'b1;
            else if (wr_req) begin
               wr_en   = ~wp_en;
               set_wp  = wp_en;
               state_n = WR_HOLD;
            end else if (rd_req) begin
               rd_inc    = READ_LAT == 0;
               load_wait = READ_LAT != 0;
               state_n   = READ_LAT == 0 ? RD_DRIVE : RD_WAIT;
            end
         RD_WAIT:
            if (!rd_req) begin
               abort   = 1'b1;
               state_n = IDLE;
            end else if (sram_addr != lat_addr) load_wait = 1'b1;
            else if (wait_cnt <= 3'd1) begin
               rd_done = 1'b1;
               rd_inc  = 1'b1;
               state_n = RD_DRIVE;
            end
         RD_DRIVE: state_n = rd_req ? RD_DRIVE : IDLE;
         WR_HOLD:  state_n = wr_req ? WR_HOLD : IDLE;
         default:  state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else state <= state_n;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         wait_cnt     <= '0;
         lat_addr     <= '0;
         dout         <= '0;
         rdy          <= 1'b1;
         err_conflict <= 1'b0;
         err_wp       <= 1'b0;
         rd_count     <= '0;
         wr_count     <= '0;
      end else begin
         wait_cnt     <= load_wait ? 3'(READ_LAT) : state == RD_WAIT ? wait_cnt - 3'd1 : wait_cnt;
         lat_addr     <= load_wait ? sram_addr : lat_addr;
         dout         <= rd_done ? rd_data : dout;
         rdy          <= load_wait ? 1'b0 : (rd_done | abort) ? 1'b1 : rdy;
         err_conflict <= err_conflict | set_conf;
         err_wp       <= err_wp | set_wp;
         rd_count     <= rd_count + {{(CNT_W-1){1'b0}}, rd_inc & ~&rd_count};
         wr_count     <= wr_count + {{(CNT_W-1){1'b0}}, wr_en & ~&wr_count};
      end
endmodule

// File: tb/tb_sram_responder.sv
// tb_sram_responder: directed checks of an asynchronous-read and a 3-wait-state responder sharing one strobe set
module tb_sram_responder;
   logic clk = 1'b0, rst = 1'b1;
   logic ce = 1'b0, oe = 1'b0, we = 1'b0, wp = 1'b0, tb_oe = 1'b0;
   logic [7:0] addr = '0, drv = '0;
   tri1 [7:0] d0, d3;
   logic rdy0, rdy3, ec0, ec3, ew0, ew3;
   logic [15:0] rc0, rc3, wc0, wc3;
   int checks = 0, failures = 0;
   always #5 clk = ~clk;
   assign d0 = tb_oe ? drv : 'z;
   assign d3 = tb_oe ? drv : 'z;
   sram_responder #(.READ_LAT(0)) dut0 (
      .clk(clk), .rst(rst), .sram_addr(addr), .sram_data(d0), .sram_ce(ce), .sram_oe(oe),
      .sram_we(we), .wp_en(wp), .rdy(rdy0), .err_conflict(ec0), .err_wp(ew0),
      .rd_count(rc0), .wr_count(wc0)
   );
   sram_responder #(.READ_LAT(3)) dut3 (
      .clk(clk), .rst(rst), .sram_addr(addr), .sram_data(d3), .sram_ce(ce), .sram_oe(oe),
      .sram_we(we), .wp_en(wp), .rdy(rdy3), .err_conflict(ec3), .err_wp(ew3),
      .rd_count(rc3), .wr_count(wc3)
   );
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask
   task automatic tick;
      @(posedge clk);
      #2;
   endtask
   task automatic idle;
      ce = 1'b0; oe = 1'b0; we = 1'b0; tb_oe = 1'b0;
   endtask
   initial begin
      tick; tick;
      rst = 1'b0;
      tick;
      chk("rst_rdy0", rdy0, 1); chk("rst_rdy3", rdy3, 1);
      chk("rst_err", {ec0, ew0, ec3, ew3}, 0);
      chk("rst_cnt", {rc0, wc0}, 0);
      chk("rst_bus0", d0, 8'hFF); chk("rst_bus3", d3, 8'hFF);
      ce = 1'b1; we = 1'b1; addr = 8'h10; drv = 8'hA5; tb_oe = 1'b1;
      tick;
      idle;
      tick;
      chk("wr_cnt0", wc0, 1); chk("wr_cnt3", wc3, 1);
      ce = 1'b1; oe = 1'b1; addr = 8'h10;
      #1;
      chk("rd0_async", d0, 8'hA5); chk("rd3_idle_z", d3, 8'hFF); chk("rd0_rdy", rdy0, 1);
      for (int i = 1; i <= 3; i++) begin
         tick;
         chk($sformatf("rd3_wait%0d_rdy", i), rdy3, 0);
         chk($sformatf("rd3_wait%0d_z", i), d3, 8'hFF);
      end
      chk("rd0_cnt", rc0, 1); chk("rd0_drive", d0, 8'hA5);
      tick;
      chk("rd3_rdy", rdy3, 1); chk("rd3_data", d3, 8'hA5); chk("rd3_cnt", rc3, 1);
      idle;
      #1;
      chk("rd3_release", d3, 8'hFF); chk("rd0_release", d0, 8'hFF);
      tick;
      ce = 1'b1; we = 1'b1; addr = 8'h20; drv = 8'h01; tb_oe = 1'b1;
      tick;
      drv = 8'h02;
      tick; tick; tick;
      idle;
      tick;
      chk("hold_wr_cnt", wc0, 2);
      ce = 1'b1; oe = 1'b1;
      #1;
      chk("hold_single_write", d0, 8'h01);
      tick;
      idle;
      tick;
      wp = 1'b1; ce = 1'b1; we = 1'b1; addr = 8'h10; drv = 8'h55; tb_oe = 1'b1;
      tick;
      idle;
      tick;
      wp = 1'b0;
      chk("wp_err0", ew0, 1); chk("wp_err3", ew3, 1); chk("wp_wr_cnt", wc0, 2);
      ce = 1'b1; oe = 1'b1;
      #1;
      chk("wp_mem", d0, 8'hA5);
      tick;
      idle;
      tick;
      chk("no_conflict_yet", ec0, 0);
      ce = 1'b1; oe = 1'b1; we = 1'b1; addr = 8'h10;
      #1;
      chk("conf_bus0_z", d0, 8'hFF);
      tick;
      chk("conf_err0", ec0, 1); chk("conf_err3", ec3, 1);
      drv = 8'h3C; tb_oe = 1'b1;
      tick;
      idle;
      tick;
      chk("conf_wr_cnt", wc0, 2);
      ce = 1'b1; oe = 1'b1;
      #1;
      chk("conf_mem", d0, 8'hA5);
      tick;
      idle;
      tick;
      ce = 1'b1; oe = 1'b1; addr = 8'h10;
      tick; tick;
      chk("pre_rst_rdy3", rdy3, 0);
      rst = 1'b1;
      #1;
      chk("arst_rdy3", rdy3, 1); chk("arst_bus3", d3, 8'hFF); chk("arst_bus0", d0, 8'hFF);
      chk("arst_cnt3", {rc3, wc3}, 0); chk("arst_cnt0", {rc0, wc0}, 0);
      chk("arst_err", {ec0, ew0, ec3, ew3}, 0);
      tick;
      idle;
      rst = 1'b0;
      tick;
      ce = 1'b1; oe = 1'b1; addr = 8'h10;
      #1;
      chk("post_rst_rd0", d0, 8'hA5);
      tick; tick; tick; tick;
      chk("post_rst_rdy3", rdy3, 1); chk("post_rst_rd3", d3, 8'hA5); chk("post_rst_cnt3", rc3, 1);
      idle;
      tick;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
